// File: rtl/feeder_pkg.sv
// Shared constants and types for the pixel feeder: frame buffer bases, FSM encoding, address helper.
package feeder_pkg;

    localparam logic [31:0] FB0_BASE = 32'h1F80_0000;
    localparam logic [31:0] FB1_BASE = 32'h1FC0_0000;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Fixed 1024-word line stride, independent of the visible width.
    function automatic logic [31:0] pix_addr(input logic sel, input logic [9:0] x, input logic [9:0] y);
        return (sel ? FB1_BASE : FB0_BASE) + {10'd0, y, x, 2'b00};
    endfunction

endpackage

// File: rtl/pixel_feeder_if.sv
// Memory read channel plus video stream between the feeder (master) and its environment (slave).
interface pixel_feeder_if;
    logic        rd_req;
    logic [31:0] rd_addr;
    logic        rd_ack;
    logic [31:0] rd_data;
    logic        rd_data_valid;
    logic [23:0] video;
    logic        video_valid;
    logic        video_ready;

    modport master (
        output rd_req, rd_addr, video, video_valid,
        input  rd_ack, rd_data, rd_data_valid, video_ready
    );

    modport slave (
        input  rd_req, rd_addr, video, video_valid,
        output rd_ack, rd_data, rd_data_valid, video_ready
    );
endinterface

// File: rtl/pixel_fifo.sv
// Purpose: synchronous power-of-two FIFO with occupancy count; head is shown combinationally.
// Latency: a pushed word is at the head the cycle after the push.
// Backpressure: pushes while full and pops while empty are dropped; callers must respect full/empty.
module pixel_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 24
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/pixel_feeder.sv
// Purpose: fetch a frame raster from memory and stream the RGB pixels to DVI, pulsing at frame end.
// Latency: a returned word is presented on video the cycle after its rd_data_valid.
// Backpressure: requests stall once in-flight plus queued pixels reach FIFO_DEPTH; video holds while not ready.
module pixel_feeder
    import feeder_pkg::*;
#(
    parameter int FRAME_W    = 800,
    parameter int FRAME_H    = 600,
    parameter int FIFO_DEPTH = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           enable,
    input  logic           fb_sel,
    pixel_feeder_if.master bus,
    output logic           frame_interrupt
);
    localparam int              CW       = $clog2(FIFO_DEPTH) + 1;
    localparam int              NPIX     = FRAME_W * FRAME_H;
    localparam int              PW       = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam logic [9:0]      X_LAST   = 10'(FRAME_W - 1);
    localparam logic [9:0]      Y_LAST   = 10'(FRAME_H - 1);
    localparam logic [PW-1:0]   PIX_LAST = PW'(NPIX - 1);
    localparam logic [CW-1:0]   CAP      = CW'(FIFO_DEPTH);

    state_t          state;
    logic            req_q;
    logic [31:0]     addr_q;
    logic [9:0]      x;
    logic [9:0]      y;
    logic [9:0]      nx;
    logic [9:0]      ny;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   reserved;
    logic [CW-1:0]   fifo_count;
    logic            fifo_full;
    logic            fifo_empty;
    logic [23:0]     head;
    logic            fb_lat;
    logic            req_sel;
    logic            frame_sel;
    logic            next_sel;
    logic            armed;
    logic [PW-1:0]   pix_cnt;
    logic            acc;
    logic            push;
    logic            pop;
    logic            first_px;
    logic            last_px;
    logic            stop_after;
    logic            room;
    logic            unused_bits;

    assign bus.rd_req      = req_q;
    assign bus.rd_addr     = addr_q;
    assign bus.video_valid = !fifo_empty;
    assign bus.video       = fifo_empty ? 24'd0 : head;

    assign acc        = req_q && bus.rd_ack;
    // Returns are only trusted once a post-reset request has been accepted.
    assign push       = bus.rd_data_valid && armed;
    assign pop        = !fifo_empty && bus.video_ready;
    assign first_px   = (x == 10'd0) && (y == 10'd0);
    assign last_px    = (x == X_LAST) && (y == Y_LAST);
    assign stop_after = acc && last_px && !enable;
    assign reserved   = outstanding + fifo_count + CW'(acc);
    assign room       = reserved < CAP;
    assign unused_bits = ^{bus.rd_data[31:24], fifo_full};

    always_comb begin
        nx = x;
        ny = y;
        if (acc) begin
            if (x == X_LAST) begin
                nx = 10'd0;
                ny = (y == Y_LAST) ? 10'd0 : y + 10'd1;
            end else begin
                nx = x + 10'd1;
            end
        end
    end

    // The selection chosen for pixel (0,0) becomes the frame's base the moment that request is taken.
    always_comb begin
        frame_sel = (acc && first_px) ? req_sel : fb_lat;
        next_sel  = ((nx == 10'd0) && (ny == 10'd0)) ? fb_sel : frame_sel;
    end

    pixel_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (24)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (bus.rd_data[23:0]),
        .pop       (pop),
        .head      (head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            req_q           <= 1'b0;
            addr_q          <= '0;
            x               <= '0;
            y               <= '0;
            outstanding     <= '0;
            fb_lat          <= 1'b0;
            req_sel         <= 1'b0;
            armed           <= 1'b0;
            pix_cnt         <= '0;
            frame_interrupt <= 1'b0;
        end else begin
            if (acc) begin
                x     <= nx;
                y     <= ny;
                armed <= 1'b1;
                if (first_px) fb_lat <= req_sel;
            end
            outstanding <= outstanding + CW'(acc) - CW'(push);

            case (state)
                IDLE:    if (enable) state <= RUN;
                RUN:     if (stop_after) state <= IDLE;
                default: state <= IDLE;
            endcase

            if (!req_q || bus.rd_ack) begin
                if ((state == RUN) && !stop_after && room) begin
                    req_q   <= 1'b1;
                    req_sel <= next_sel;
                    addr_q  <= pix_addr(next_sel, nx, ny);
                end else begin
                    req_q <= 1'b0;
                end
            end

            frame_interrupt <= 1'b0;
            if (pop) begin
                if (pix_cnt == PIX_LAST) begin
                    pix_cnt         <= '0;
                    frame_interrupt <= 1'b1;
                end else begin
                    pix_cnt <= pix_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pixel_feeder.sv
// Bench for pixel_feeder on a 4x2 frame: memory responder, scoreboard model, directed and random scenarios.
module tb_pixel_feeder;
    import feeder_pkg::*;

    localparam int W = 4;
    localparam int H = 2;
    localparam int D = 8;
    localparam int NPIX = W * H;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic enable = 1'b0;
    logic fb_sel = 1'b0;
    logic frame_interrupt;

    pixel_feeder_if bus();

    pixel_feeder #(.FRAME_W(W), .FRAME_H(H), .FIFO_DEPTH(D)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .enable          (enable),
        .fb_sel          (fb_sel),
        .bus             (bus),
        .frame_interrupt (frame_interrupt)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- memory responder ----------------
    typedef struct { logic [31:0] addr; int due; } ret_t;
    ret_t rq[$];
    int ack_pct = 100;
    int ready_pct = 100;
    int lat_min = 0;
    int lat_max = 0;
    int cyc = 0;

    initial begin
        logic acc_s;
        logic [31:0] addr_s;
        int due;
        int last_due;
        last_due = 0;
        bus.rd_ack = 1'b0;
        bus.rd_data = '0;
        bus.rd_data_valid = 1'b0;
        bus.video_ready = 1'b0;
        forever begin
            @(negedge clk);
            acc_s = bus.rd_req && bus.rd_ack;
            addr_s = bus.rd_addr;
            @(posedge clk);
            #1;
            cyc++;
            if (acc_s && rst_n) begin
                due = cyc + $urandom_range(lat_min, lat_max);
                if (due < last_due) due = last_due;
                last_due = due;
                rq.push_back('{addr_s, due});
            end
            if (rq.size() > 0 && rq[0].due <= cyc) begin
                bus.rd_data_valid = 1'b1;
                bus.rd_data = rq[0].addr;
                void'(rq.pop_front());
            end else begin
                bus.rd_data_valid = 1'b0;
                bus.rd_data = $urandom;
            end
            bus.rd_ack = ($urandom_range(1, 100) <= ack_pct);
            bus.video_ready = ($urandom_range(1, 100) <= ready_pct);
        end
    end

    // ---------------- reference model / scoreboard ----------------
    logic [31:0] exp_q[$];
    logic [31:0] acc_log[$];
    logic [23:0] pop_log[$];
    int irq_at[$];
    int occ_m, inflight_m, p_req, pop_cnt_m;
    int total_acc, total_pop, irq_count, req_cycles;
    bit armed_m, sel_m, irq_exp, prev_req, prev_ack;
    logic [31:0] prev_addr;

    initial begin
        logic pop;
        logic [31:0] ea;
        logic [31:0] hd;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete(); acc_log.delete(); pop_log.delete(); irq_at.delete();
                occ_m = 0; inflight_m = 0; p_req = 0; pop_cnt_m = 0;
                total_acc = 0; total_pop = 0; irq_count = 0; req_cycles = 0;
                armed_m = 0; sel_m = 0; irq_exp = 0; prev_req = 0; prev_ack = 0;
            end else begin
                check("frame_interrupt", frame_interrupt, irq_exp);
                if (frame_interrupt) begin
                    irq_count++;
                    irq_at.push_back(total_pop - 1);
                end
                check("video_valid", bus.video_valid, occ_m > 0);
                if (bus.rd_req) req_cycles++;
                if (prev_req && !prev_ack) begin
                    check("rd_req_hold", bus.rd_req, 1);
                    check("rd_addr_hold", bus.rd_addr, prev_addr);
                end else if (bus.rd_req) begin
                    check("rd_req_room", (inflight_m + occ_m) < D, 1);
                end
                pop = bus.video_valid && bus.video_ready;
                irq_exp = 0;
                if (pop) begin
                    if (exp_q.size() == 0) begin
                        check("video_unexpected", bus.video, 32'hDEAD_BEEF);
                    end else begin
                        hd = exp_q.pop_front();
                        check("video", bus.video, {8'd0, hd[23:0]});
                    end
                    pop_log.push_back(bus.video);
                    total_pop++;
                    pop_cnt_m++;
                    if (pop_cnt_m == NPIX) begin
                        irq_exp = 1;
                        pop_cnt_m = 0;
                    end
                    occ_m--;
                end
                if (bus.rd_data_valid && armed_m) begin
                    occ_m++;
                    inflight_m--;
                end
                if (bus.rd_req && bus.rd_ack) begin
                    if (p_req == 0) sel_m = fb_sel;
                    ea = (sel_m ? FB1_BASE : FB0_BASE) + 32'((p_req / W) * 4096 + (p_req % W) * 4);
                    check("rd_addr", bus.rd_addr, ea);
                    exp_q.push_back(ea);
                    acc_log.push_back(bus.rd_addr);
                    p_req = (p_req + 1) % NPIX;
                    inflight_m++;
                    total_acc++;
                    armed_m = 1;
                end
                check("occupancy_bound", (inflight_m + occ_m) <= D, 1);
                prev_req = bus.rd_req;
                prev_ack = bus.rd_ack;
                prev_addr = bus.rd_addr;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic timeout(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: wait budget expired, got acc=%0d pop=%0d", name, total_acc, total_pop);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        enable = 1'b0;
        fb_sel = 1'b0;
        rq.delete();
        cycles(3);
        rst_n = 1'b1;
        cycles(1);
    endtask

    task automatic wait_acc(input int n, input string name);
        int c = 0;
        while (total_acc < n && c < 1000) begin cycles(1); c++; end
        if (total_acc < n) timeout(name);
    endtask

    task automatic drain(input string name);
        int c = 0;
        while (!(bus.rd_req == 1'b0 && total_acc > 0 && total_acc % NPIX == 0 &&
                 total_pop == total_acc && occ_m == 0) && c < 3000) begin
            cycles(1);
            c++;
        end
        if (c >= 3000) timeout(name);
        cycles(3);
    endtask

    task automatic idle_check(input string name);
        int snap;
        snap = req_cycles;
        cycles(30);
        check(name, req_cycles, snap);
    endtask

    typedef struct { int pop_idx; logic [23:0] video; bit irq; } vec_t;
    vec_t tbl[NPIX];

    // ---------------- scenarios ----------------
    initial begin
        int got;
        int c;
        tbl[0] = '{0, 24'h800000, 1'b0};
        tbl[1] = '{1, 24'h800004, 1'b0};
        tbl[2] = '{2, 24'h800008, 1'b0};
        tbl[3] = '{3, 24'h80000C, 1'b0};
        tbl[4] = '{4, 24'h801000, 1'b0};
        tbl[5] = '{5, 24'h801004, 1'b0};
        tbl[6] = '{6, 24'h801008, 1'b0};
        tbl[7] = '{7, 24'h80100C, 1'b1};

        #1;
        check("rst_rd_req", bus.rd_req, 0);
        check("rst_rd_addr", bus.rd_addr, 0);
        check("rst_video_valid", bus.video_valid, 0);
        check("rst_video", bus.video, 0);
        check("rst_irq", frame_interrupt, 0);
        do_reset();

        // Single frame, no stalls, data = address one cycle after ack.
        ack_pct = 100; ready_pct = 100; lat_min = 0; lat_max = 0;
        enable = 1'b1;
        wait_acc(1, "a_start");
        enable = 1'b0;
        drain("a_drain");
        check("a_pop_count", pop_log.size(), NPIX);
        for (int i = 0; i < NPIX; i++) begin
            if (i < pop_log.size()) check("tbl_video", pop_log[tbl[i].pop_idx], tbl[i].video);
            got = 0;
            foreach (irq_at[k]) if (irq_at[k] == tbl[i].pop_idx) got = 1;
            check("tbl_irq", got, tbl[i].irq);
        end
        check("a_irq_count", irq_count, 1);
        idle_check("a_idle_no_req");

        // Backpressure: ready held low for 20 cycles.
        do_reset();
        ready_pct = 0;
        enable = 1'b1;
        cycles(20);
        check("b_req_stopped", bus.rd_req, 0);
        check("b_reserved", total_acc, D);
        check("b_no_pop", total_pop, 0);
        ready_pct = 100;
        cycles(15);
        enable = 1'b0;
        drain("b_drain");
        check("b_all_delivered", total_pop, total_acc);

        // fb_sel toggled mid-frame.
        do_reset();
        enable = 1'b1;
        wait_acc(3, "c_mid");
        fb_sel = 1'b1;
        wait_acc(NPIX + 1, "c_next");
        enable = 1'b0;
        drain("c_drain");
        check("c_last_fb0", acc_log[NPIX-1], 32'h1F80_100C);
        check("c_first_fb1", acc_log[NPIX], 32'h1FC0_0000);
        check("c_total", total_acc, 2 * NPIX);

        // Enable dropped at pixel 3 under random stalls.
        do_reset();
        ack_pct = 70; ready_pct = 60; lat_min = 0; lat_max = 3;
        enable = 1'b1;
        wait_acc(3, "d_px3");
        enable = 1'b0;
        drain("d_drain");
        check("d_pops", total_pop, NPIX);
        check("d_acc", total_acc, NPIX);
        check("d_irq", irq_count, 1);
        idle_check("d_idle_no_req");

        // Randomised streaming with mid-frame buffer toggles.
        do_reset();
        ack_pct = 60; ready_pct = 70; lat_min = 0; lat_max = 4;
        enable = 1'b1;
        for (int i = 0; i < 800; i++) begin
            if (p_req >= 2 && p_req <= 5 && $urandom_range(0, 9) == 0) fb_sel = ~fb_sel;
            if (i % 200 == 0) ready_pct = $urandom_range(20, 100);
            cycles(1);
        end
        enable = 1'b0;
        drain("e_drain");
        check("e_balance", total_pop, total_acc);
        check("e_irq", irq_count, total_acc / NPIX);

        // Async reset with three requests in flight; stale returns must be ignored.
        do_reset();
        ack_pct = 100; ready_pct = 100; lat_min = 10; lat_max = 10;
        enable = 1'b1;
        c = 0;
        while (inflight_m < 3 && c < 200) begin cycles(1); c++; end
        if (inflight_m < 3) timeout("f_inflight");
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        enable = 1'b0;
        ack_pct = 0;
        #1;
        check("f_rd_req", bus.rd_req, 0);
        check("f_rd_addr", bus.rd_addr, 0);
        check("f_video_valid", bus.video_valid, 0);
        check("f_video", bus.video, 0);
        check("f_irq", frame_interrupt, 0);
        cycles(3);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("f_stale_video_valid", bus.video_valid, 0);
        end
        cycles(1);
        ack_pct = 100; lat_min = 0; lat_max = 0;
        enable = 1'b1;
        wait_acc(1, "f_restart");
        enable = 1'b0;
        drain("f_drain");
        check("f_post_pops", total_pop, NPIX);
        check("f_post_first", acc_log[0], 32'h1F80_0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
